// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator.
package pc_pkg;
    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JALR   = 3'b010,
        PC_TRAP   = 3'b011,
        PC_MRET   = 3'b100
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;
endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: combinational redirect target mux with jalr bit-0 clear and alignment check.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int IALIGN = 4
) (
    input  logic [2:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [XLEN-1:0] epc,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    localparam logic [XLEN-1:0] AMASK = XLEN'(IALIGN - 1);

    logic            is_br, is_jalr, is_trap, is_mret;
    logic [XLEN-1:0] raw;

    assign is_br   = pc_src == PC_BRANCH;
    assign is_jalr = pc_src == PC_JALR;
    assign is_trap = pc_src == PC_TRAP;
    assign is_mret = pc_src == PC_MRET;

    assign raw = is_trap ? trap_vector :
                 is_mret ? epc :
                 is_jalr ? (jalr_target & ~XLEN'(1)) : branch_target;

    assign redirect   = is_br | is_jalr | is_trap | is_mret;
    // Trap and mret targets are forced aligned; only control-flow targets can fault.
    assign target     = (is_trap | is_mret) ? (raw & ~AMASK) : raw;
    assign misaligned = (is_br | is_jalr) && |(raw & AMASK);
endmodule

// File: rtl/pc_gen.sv
// pc_gen: owned PC register with fetch handshake, stall/halt FSM and redirect handling.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [XLEN-1:0] epc,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic            halted
);
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, maddr_q, maddr_d;
    logic            mexc_q, mexc_d;
    logic            redirect, misaligned;
    logic [XLEN-1:0] target;

    pc_target_sel #(.XLEN(XLEN), .IALIGN(IALIGN)) u_sel (
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .trap_vector   (trap_vector),
        .epc           (epc),
        .redirect      (redirect),
        .target        (target),
        .misaligned    (misaligned)
    );

    assign fetch_valid   = state_q == RUN;
    assign halted        = state_q == HALT;
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + XLEN'(4);
    assign misalign_exc  = mexc_q;
    assign misalign_addr = maddr_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mexc_d  = 1'b0;
        maddr_d = maddr_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // Redirects override stall and backpressure; the outstanding request is dropped.
                if (redirect && misaligned) begin
                    mexc_d  = 1'b1;
                    maddr_d = target;
                end else if (redirect)
                    pc_d = target;
                else if (fetch_ready && !stall)
                    pc_d = pc_plus4;
                state_d = halt_req ? HALT : RUN;
            end
            HALT: state_d = resume ? RUN : HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            mexc_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mexc_q  <= mexc_d;
            maddr_q <= maddr_d;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed tests for pc_gen; a second instance with IALIGN=2 shares all inputs.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, halt_req, resume, fetch_ready;
    logic [2:0]  pc_src;
    logic [31:0] branch_target, jalr_target, trap_vector, epc;
    logic        fv, exc, hlt, fv2, exc2, hlt2;
    logic [31:0] pc, pc4, maddr, pc2, pc42, maddr2;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(4)) u_dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target),
        .jalr_target(jalr_target), .trap_vector(trap_vector), .epc(epc),
        .stall(stall), .halt_req(halt_req), .resume(resume), .fetch_ready(fetch_ready),
        .fetch_valid(fv), .pc(pc), .pc_plus4(pc4), .misalign_exc(exc),
        .misalign_addr(maddr), .halted(hlt)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(2)) u_dut2 (
        .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target),
        .jalr_target(jalr_target), .trap_vector(trap_vector), .epc(epc),
        .stall(stall), .halt_req(halt_req), .resume(resume), .fetch_ready(fetch_ready),
        .fetch_valid(fv2), .pc(pc2), .pc_plus4(pc42), .misalign_exc(exc2),
        .misalign_addr(maddr2), .halted(hlt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b0;
        pc_src = 3'b000; branch_target = '0; jalr_target = '0; trap_vector = '0; epc = '0;
        step(); step();
        tests++; if (fv !== 1'b0 || pc !== 32'h100 || hlt !== 1'b0 || exc !== 1'b0 || maddr !== 32'h0) begin
            failed++; $display("FAIL reset_state fv=%b pc=%h halted=%b exc=%b maddr=%h want 0 100 0 0 0", fv, pc, hlt, exc, maddr);
        end
        rst = 1'b0;
        #3;
        tests++; if (fv !== 1'b0) begin failed++; $display("FAIL boot_fv got %b want 0", fv); end
        step();
        tests++; if (fv !== 1'b1 || pc !== 32'h100) begin
            failed++; $display("FAIL first_fetch fv=%b pc=%h want 1 00000100", fv, pc);
        end
        tests++; if (pc4 !== 32'h104) begin failed++; $display("FAIL pc_plus4 got %h want 00000104", pc4); end
        fetch_ready = 1'b1;
        step();
        tests++; if (pc !== 32'h104) begin failed++; $display("FAIL seq1 got %h want 00000104", pc); end
        step();
        tests++; if (pc !== 32'h108) begin failed++; $display("FAIL seq2 got %h want 00000108", pc); end
    endtask

    task automatic test_backpressure();
        fetch_ready = 1'b0; pc_src = 3'b001; branch_target = 32'h20;
        step();
        tests++; if (pc !== 32'h20) begin failed++; $display("FAIL bp_redirect got %h want 00000020", pc); end
        pc_src = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (pc !== 32'h20 || fv !== 1'b1) begin
                failed++; $display("FAIL bp_hold%0d pc=%h fv=%b want 00000020 1", i, pc, fv);
            end
        end
        stall = 1'b1; fetch_ready = 1'b1;
        step();
        tests++; if (pc !== 32'h20) begin failed++; $display("FAIL stall_hold got %h want 00000020", pc); end
        stall = 1'b0;
        step();
        tests++; if (pc !== 32'h24) begin failed++; $display("FAIL stall_release got %h want 00000024", pc); end
        pc_src = 3'b111;
        step();
        tests++; if (pc !== 32'h28) begin failed++; $display("FAIL src_other_seq got %h want 00000028", pc); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; fetch_ready = 1'b0; pc_src = 3'b001; branch_target = 32'h400;
        step();
        tests++; if (pc !== 32'h400 || exc !== 1'b0) begin
            failed++; $display("FAIL branch_stall pc=%h exc=%b want 00000400 0", pc, exc);
        end
        pc_src = 3'b010; jalr_target = 32'h301;
        step();
        tests++; if (pc !== 32'h300 || exc !== 1'b0) begin
            failed++; $display("FAIL jalr_clear pc=%h exc=%b want 00000300 0", pc, exc);
        end
        tests++; if (pc2 !== 32'h300) begin failed++; $display("FAIL jalr_clear_a2 got %h want 00000300", pc2); end
    endtask

    task automatic test_misalign();
        pc_src = 3'b001; branch_target = 32'h402;
        step();
        tests++; if (pc !== 32'h300 || exc !== 1'b1 || maddr !== 32'h402) begin
            failed++; $display("FAIL misalign pc=%h exc=%b maddr=%h want 00000300 1 00000402", pc, exc, maddr);
        end
        tests++; if (pc2 !== 32'h402 || exc2 !== 1'b0) begin
            failed++; $display("FAIL align2_ok pc=%h exc=%b want 00000402 0", pc2, exc2);
        end
        pc_src = 3'b000;
        step();
        tests++; if (exc !== 1'b0 || maddr !== 32'h402 || pc !== 32'h300) begin
            failed++; $display("FAIL misalign_pulse exc=%b maddr=%h pc=%h want 0 00000402 00000300", exc, maddr, pc);
        end
        pc_src = 3'b001; branch_target = 32'h406;
        step();
        tests++; if (exc !== 1'b1 || maddr !== 32'h406) begin
            failed++; $display("FAIL b2b_first exc=%b maddr=%h want 1 00000406", exc, maddr);
        end
        pc_src = 3'b010; jalr_target = 32'h40B;
        step();
        tests++; if (exc !== 1'b1 || maddr !== 32'h40A || pc !== 32'h300) begin
            failed++; $display("FAIL b2b_second exc=%b maddr=%h pc=%h want 1 0000040a 00000300", exc, maddr, pc);
        end
        tests++; if (pc2 !== 32'h40A || exc2 !== 1'b0) begin
            failed++; $display("FAIL b2b_a2 pc=%h exc=%b want 0000040a 0", pc2, exc2);
        end
        pc_src = 3'b000;
        step();
        tests++; if (exc !== 1'b0) begin failed++; $display("FAIL b2b_end got %b want 0", exc); end
    endtask

    task automatic test_trap_mret();
        pc_src = 3'b011; trap_vector = 32'h8000_0003;
        step();
        tests++; if (pc !== 32'h8000_0000 || exc !== 1'b0) begin
            failed++; $display("FAIL trap pc=%h exc=%b want 80000000 0", pc, exc);
        end
        tests++; if (pc2 !== 32'h8000_0002 || exc2 !== 1'b0) begin
            failed++; $display("FAIL trap_a2 pc=%h exc=%b want 80000002 0", pc2, exc2);
        end
        pc_src = 3'b100; epc = 32'h44;
        step();
        tests++; if (pc !== 32'h44 || pc2 !== 32'h44) begin
            failed++; $display("FAIL mret pc=%h pc2=%h want 00000044", pc, pc2);
        end
    endtask

    task automatic test_halt_wrap();
        stall = 1'b0; fetch_ready = 1'b0; pc_src = 3'b001; branch_target = 32'hFFFF_FFFC;
        step();
        tests++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
            failed++; $display("FAIL wrap_setup pc=%h pc4=%h want fffffffc 00000000", pc, pc4);
        end
        pc_src = 3'b000; fetch_ready = 1'b1;
        step();
        tests++; if (pc !== 32'h0) begin failed++; $display("FAIL wrap got %h want 00000000", pc); end
        pc_src = 3'b001; branch_target = 32'h80; halt_req = 1'b1;
        step();
        tests++; if (pc !== 32'h80 || hlt !== 1'b1 || fv !== 1'b0) begin
            failed++; $display("FAIL halt_entry pc=%h halted=%b fv=%b want 00000080 1 0", pc, hlt, fv);
        end
        halt_req = 1'b0; branch_target = 32'h200;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (pc !== 32'h80 || hlt !== 1'b1 || fv !== 1'b0) begin
                failed++; $display("FAIL halt_frozen%0d pc=%h halted=%b fv=%b want 00000080 1 0", i, pc, hlt, fv);
            end
        end
        pc_src = 3'b000; fetch_ready = 1'b0; halt_req = 1'b1; resume = 1'b1;
        step();
        tests++; if (hlt !== 1'b0 || fv !== 1'b1 || pc !== 32'h80) begin
            failed++; $display("FAIL resume pc=%h halted=%b fv=%b want 00000080 0 1", pc, hlt, fv);
        end
        resume = 1'b0;
        step();
        tests++; if (hlt !== 1'b1) begin failed++; $display("FAIL rehalt got %b want 1", hlt); end
        halt_req = 1'b0; rst = 1'b1;
        step();
        tests++; if (hlt !== 1'b0 || fv !== 1'b0 || pc !== 32'h100) begin
            failed++; $display("FAIL halt_reset pc=%h halted=%b fv=%b want 00000100 0 0", pc, hlt, fv);
        end
        rst = 1'b0;
        step();
        tests++; if (fv !== 1'b1 || pc !== 32'h100) begin
            failed++; $display("FAIL post_reset fv=%b pc=%h want 1 00000100", fv, pc);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_stall();
        test_misalign();
        test_trap_mret();
        test_halt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the RV32 core. It supersedes the bare next-PC mux with an owned PC register, a fetch valid/ready handshake, stall and halt control, and extra redirect sources (trap entry, trap return). It checks redirect-target alignment and flags misaligned targets as exceptions. It sits between the control/branch unit and the instruction-fetch port.

Parameters:
XLEN, 32, PC and target width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
IALIGN, 4, required instruction alignment in bytes (2 or 4); alignment mask = IALIGN-1

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-high
pc_src  in  3  redirect select: 000 seq, 001 branch/jal, 010 jalr, 011 trap, 100 mret, others = seq
branch_target  in  XLEN  pc + imm
jalr_target  in  XLEN  rs1 + imm (bit 0 cleared internally)
trap_vector  in  XLEN  mtvec base
epc  in  XLEN  mepc for mret
stall  in  1  hold PC (hazard)
halt_req  in  1  request fetch halt (debug/UART loader)
resume  in  1  leave halt
fetch_ready  in  1  imem accepted current address
fetch_valid  out  1  pc is a valid fetch request
pc  out  XLEN  current fetch address
pc_plus4  out  XLEN  pc + 4
misalign_exc  out  1  one-cycle pulse, misaligned redirect target
misalign_addr  out  XLEN  offending target, held until next exception
halted  out  1  FSM in HALT

Behaviour:
- Reset: sync on rst=1 at posedge clk. State=BOOT, pc=RESET_VECTOR, fetch_valid=0, misalign_exc=0, misalign_addr=0, halted=0. rst has priority over every other input.
- FSM BOOT -> RUN after exactly one cycle. fetch_valid=0 in BOOT; first request presents RESET_VECTOR in cycle 2 after rst deasserts.
- RUN, priority per cycle (highest first):
  - trap (011): pc<=trap_vector, masked to alignment. Never raises misalign.
  - mret (100): pc<=epc, masked.
  - branch/jal (001) / jalr (010): target = branch_target, or {jalr_target[XLEN-1:1],0}.
    - If target & (IALIGN-1) != 0: pc holds, misalign_exc=1 next cycle, misalign_addr<=target.
    - Else pc<=target.
  - Redirects apply even when stall=1 or fetch_ready=0; the outstanding request is abandoned.
  - seq (000/others): pc<=pc+4 only if fetch_valid & fetch_ready & !stall; otherwise hold.
- fetch_valid=1 in RUN. While fetch_valid=1 and fetch_ready=0, pc must remain stable unless a redirect occurs.
- halt_req in RUN: a pending redirect in the same cycle is still applied; then state->HALT. In HALT: fetch_valid=0, halted=1, pc frozen, pc_src ignored. resume in HALT -> RUN next cycle; pc unchanged.
- halt_req and resume both high in HALT: resume wins.
- Arithmetic: pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0). Registered pc, one-cycle redirect latency. pc_plus4 is combinational.
- misalign_exc is a 1-cycle pulse. Back-to-back misaligned redirects produce back-to-back pulses.

Decomposition:
- Package pc_pkg:
  - pc_src_e enum (PC_SEQ, PC_BRANCH, PC_JALR, PC_TRAP, PC_MRET)
  - pc_state_e enum (BOOT, RUN, HALT)
  - XLEN default constant
- Sub-module pc_target_sel: combinational target mux, jalr bit-0 clear, alignment check. Outputs target and misaligned. pc_gen owns the register and FSM.

Test Plan:
- Reset: rst high 2 cycles, RESET_VECTOR=0x100 -> fetch_valid=0 for 1 cycle after release, then pc=0x100; fetch_ready=1 for 3 cycles -> pc sequence 0x100, 0x104, 0x108.
- Backpressure: fetch_ready=0 for 4 cycles at pc=0x20 -> pc stays 0x20; stall=1 with ready=1 -> pc holds.
- Redirect under stall: stall=1, pc_src=001, branch_target=0x400 -> next pc=0x400. jalr_target=0x301, IALIGN=4 -> target 0x300, pc=0x300.
- Misalign: IALIGN=4, branch_target=0x402 -> pc holds, misalign_exc pulses 1 cycle, misalign_addr=0x402. IALIGN=2 same stimulus -> pc=0x402, no exception.
- Trap/mret: pc_src=011, trap_vector=0x8000_0003 -> pc=0x8000_0000 (masked). Then pc_src=100, epc=0x44 -> pc=0x44.
- Halt/wrap: pc=0xFFFF_FFFC with ready=1 -> pc=0x0. Then halt_req -> halted=1, fetch_valid=0, pc frozen 5 cycles. resume -> RUN, pc unchanged. rst asserted during HALT -> BOOT, pc=RESET_VECTOR.
